// File: rtl/weight_fetch.sv
// Streaming weight-memory read engine: issues a burst of sequential reads and
// presents the returned words downstream on a valid/ready stream with a last marker.
module weight_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_w_valid,
    input  logic                  i_w_ready,
    output logic [DATA_WIDTH-1:0] o_w_data,
    output logic                  o_w_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_done;
    logic                    w_done_nxt;

    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH:0]     r_len;
    logic [ADDR_WIDTH:0]     r_issued;
    logic [ADDR_WIDTH:0]     r_popped;
    logic                    r_inflight;

    logic [DATA_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic                    w_accept;
    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_pop;
    logic [OCC_W-1:0]        w_occupancy;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    // Words buffered plus the read still in flight must fit, so a push can never overflow.
    assign w_occupancy  = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_issue      = (r_state == S_FETCH) && (r_issued < r_len) &&
                          (w_occupancy < OCC_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && ((r_issued + (ADDR_WIDTH+1)'(1)) == r_len);
    assign w_push       = r_inflight;
    assign w_pop        = o_w_valid && i_w_ready;
    assign w_last_pop   = w_pop && o_w_last;

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_mem_en   = w_issue;
    assign o_mem_we   = 1'b0;
    assign o_mem_addr = r_base + r_issued[ADDR_WIDTH-1:0];
    assign o_w_valid  = (r_count != '0);
    assign o_w_data   = o_w_valid ? r_fifo[r_rd_ptr] : '0;
    assign o_w_last   = o_w_valid && (r_popped == (r_len - (ADDR_WIDTH+1)'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Command registers only change on an accepted nonzero start, so starts while busy are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_popped <= '0;
        end else if (w_accept && (i_len != '0)) begin
            r_base   <= i_base_addr;
            r_len    <= i_len;
            r_issued <= '0;
            r_popped <= '0;
        end else begin
            if (w_issue) begin
                r_issued <= r_issued + (ADDR_WIDTH+1)'(1);
            end
            if (w_pop) begin
                r_popped <= r_popped + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux zeroes w_data while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: a registered-read memory model, expected
// addresses and words queued at each start and compared as the DUT produces them.
module tb_weight_fetch;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   lenIn;
    logic          busy;
    logic          done;
    logic          memEn;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memRdata;
    logic          wValid;
    logic          wReady;
    logic [DW-1:0] wData;
    logic          wLast;

    weight_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_base_addr (baseAddr),
        .i_len       (lenIn),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_en    (memEn),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .i_mem_rdata (memRdata),
        .o_w_valid   (wValid),
        .i_w_ready   (wReady),
        .o_w_data    (wData),
        .o_w_last    (wLast)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] memArr [1 << AW];
    always @(posedge clk) begin
        if (memEn) memRdata <= memArr[memAddr];
    end

    int cycleCount = 0;
    always @(posedge clk) cycleCount++;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    logic [AW-1:0] addrQ [$];
    logic [DW:0]   wordQ [$];

    int startBase = 0;
    int curLen = 0;
    int firstEnRel = -1;
    int firstValidRel = -1;
    int lastHsRel = -1;
    int issuedCnt = 0;
    int poppedCnt = 0;
    int maxOut = 0;
    int doneTotal = 0;
    int expDone = 0;
    bit stallSeen = 0;
    bit prevStall = 0;
    logic [DW-1:0] prevData;
    logic prevLast;

    // Monitor: samples mid-cycle, scores reads and handshakes, and checks hold behaviour.
    always @(negedge clk) begin
        int rel;
        int outstanding;
        logic [DW:0] expWord;
        if (!rstN) begin
            prevStall = 0;
        end else begin
            rel = cycleCount - startBase;
            if (prevStall) begin
                checkOutput("hold_valid", wValid, 1);
                checkOutput("hold_data", wData, prevData);
                checkOutput("hold_last", wLast, prevLast);
            end
            prevStall = wValid && !wReady;
            prevData  = wData;
            prevLast  = wLast;
            if (memEn) begin
                issuedCnt++;
                if (firstEnRel < 0) firstEnRel = rel;
                if (addrQ.size() == 0) checkOutput("extra_read", 1, 0);
                else checkOutput("mem_addr", memAddr, addrQ.pop_front());
            end else if (busy && issuedCnt < curLen) begin
                stallSeen = 1;
            end
            if (wValid && firstValidRel < 0) firstValidRel = rel;
            if (wValid && wReady) begin
                poppedCnt++;
                if (wordQ.size() == 0) begin
                    checkOutput("extra_word", 1, 0);
                end else begin
                    expWord = wordQ.pop_front();
                    checkOutput("w_data", wData, expWord[DW-1:0]);
                    checkOutput("w_last", wLast, expWord[DW]);
                end
                if (wLast) lastHsRel = rel;
            end
            if (done) doneTotal++;
            outstanding = issuedCnt - poppedCnt;
            if (outstanding > maxOut) maxOut = outstanding;
            if (!wReady) checkOutput("occupancy_bound", outstanding <= DEPTH, 1);
        end
    end

    // Called just after a rising edge; returns in the done cycle so the next start lands there.
    task automatic applyStimulus(input logic [AW-1:0] base, input int len, input int bpLo, input int bpHi,
                                 input bit randReady, input int intrudeAt, input int abortAt,
                                 output int doneRel);
        int rel;
        bit aborted;
        aborted = 0;
        doneRel = -1;
        startBase = cycleCount;
        curLen = len;
        firstEnRel = -1;
        firstValidRel = -1;
        lastHsRel = -1;
        issuedCnt = 0;
        poppedCnt = 0;
        maxOut = 0;
        stallSeen = 0;
        for (int i = 0; i < len; i++) begin
            addrQ.push_back(AW'(base + AW'(i)));
            wordQ.push_back({(i == len - 1), memArr[AW'(base + AW'(i))]});
        end
        baseAddr = base;
        lenIn = (AW+1)'(len);
        start = 1'b1;
        for (int c = 0; c < 4 * len + 64; c++) begin
            rel = cycleCount - startBase;
            if (rel == intrudeAt) begin
                start = 1'b1;
                baseAddr = 10'h200;
                lenIn = 11'd3;
            end
            wReady = randReady ? 1'($urandom_range(0, 1)) : !(rel >= bpLo && rel <= bpHi);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (abortAt >= 0 && (cycleCount - startBase) == abortAt) begin
                rstN = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_mem_en", memEn, 0);
                checkOutput("abort_mem_addr", memAddr, 0);
                checkOutput("abort_w_valid", wValid, 0);
                checkOutput("abort_w_last", wLast, 0);
                checkOutput("abort_w_data", wData, 0);
                addrQ.delete();
                wordQ.delete();
                aborted = 1;
                break;
            end
            if (done) begin
                doneRel = cycleCount - startBase;
                break;
            end
        end
        if (!aborted) begin
            expDone++;
            if (doneRel < 0) checkOutput("done_timeout", 0, 1);
            checkOutput("addr_queue_drained", addrQ.size(), 0);
            checkOutput("word_queue_drained", wordQ.size(), 0);
        end
    endtask

    initial begin
        int dr;
        for (int i = 0; i < (1 << AW); i++) memArr[i] = DW'(i);
        rstN = 1'b0;
        start = 1'b0;
        baseAddr = '0;
        lenIn = '0;
        wReady = 1'b0;
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_mem_en", memEn, 0);
        checkOutput("reset_mem_addr", memAddr, 0);
        checkOutput("reset_w_valid", wValid, 0);
        checkOutput("reset_w_last", wLast, 0);
        checkOutput("reset_w_data", wData, 0);
        checkOutput("mem_we_low", memWe, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic burst");
        applyStimulus(10'h010, 8, -1, -1, 0, -1, -1, dr);
        checkOutput("basic_first_en", firstEnRel, 1);
        checkOutput("basic_first_valid", firstValidRel, 3);
        checkOutput("basic_last_hs", lastHsRel, 10);
        checkOutput("basic_done", dr, 11);

        $display("[TB] wrap-around");
        applyStimulus(10'h3FE, 4, -1, -1, 0, -1, -1, dr);
        checkOutput("wrap_done", dr, 7);

        $display("[TB] backpressure");
        applyStimulus(10'h040, 16, 4, 12, 0, -1, -1, dr);
        checkOutput("bp_stall_seen", stallSeen, 1);
        checkOutput("bp_max_buffered", maxOut, DEPTH);
        checkOutput("bp_words", poppedCnt, 16);

        $display("[TB] zero length");
        applyStimulus(10'h100, 0, -1, -1, 0, -1, -1, dr);
        checkOutput("zero_done", dr, 1);
        checkOutput("zero_no_reads", issuedCnt, 0);

        $display("[TB] start while busy");
        applyStimulus(10'h020, 8, -1, -1, 0, 4, -1, dr);
        checkOutput("busy_start_done", dr, 11);

        $display("[TB] full memory then back-to-back");
        applyStimulus(10'h000, 1024, -1, -1, 0, -1, -1, dr);
        checkOutput("full_done", dr, 1027);
        checkOutput("full_words", poppedCnt, 1024);
        applyStimulus(10'h123, 5, -1, -1, 0, -1, -1, dr);
        checkOutput("b2b_first_en", firstEnRel, 1);
        checkOutput("b2b_done", dr, 8);

        $display("[TB] random ready");
        applyStimulus(10'h3F0, 20, -1, -1, 1, -1, -1, dr);
        checkOutput("rand_words", poppedCnt, 20);

        $display("[TB] reset mid-burst");
        applyStimulus(10'h000, 10, -1, -1, 0, -1, 8, dr);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("in_reset_done", done, 0);
        end
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_abort_done", done, 0);
        checkOutput("after_abort_busy", busy, 0);
        applyStimulus(10'h010, 8, -1, -1, 0, -1, -1, dr);
        checkOutput("post_reset_first_en", firstEnRel, 1);
        checkOutput("post_reset_first_valid", firstValidRel, 3);
        checkOutput("post_reset_last_hs", lastHsRel, 10);
        checkOutput("post_reset_done", dr, 11);

        @(posedge clk); #1;
        checkOutput("done_total", doneTotal, expDone);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Streaming read engine that sits directly upstream of the PE array, on the read side of the weight memory. On a start command it issues a burst of sequential single-cycle reads to one weight-memory port, absorbs the one-cycle read latency in a small credit-managed FIFO, and presents the weights downstream on a valid/ready stream with a last marker. It never writes memory; the top level ties the memory port's write enable low.

## Interface
- `DATA_WIDTH`, 32, weight word width; must match the memory.
- `ADDR_WIDTH`, 10, memory address width; the memory holds 2^ADDR_WIDTH words.
- `FIFO_DEPTH`, 4, output buffer entries; must be a power of two and ≥ 2. Full throughput requires ≥ 3.

- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle command strobe; sampled only in IDLE.
- `base_addr` input ADDR_WIDTH: first word address; latched on an accepted `start`.
- `len` input ADDR_WIDTH+1: burst length in words, 0 to 2^ADDR_WIDTH; latched on an accepted `start`.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-cycle pulse at the end of each burst.
- `mem_en` output 1: read enable to the memory port.
- `mem_addr` output ADDR_WIDTH: read address.
- `mem_rdata` input DATA_WIDTH: read data, valid the cycle after `mem_en`.
- `w_valid` output 1: a downstream weight is presented.
- `w_ready` input 1: downstream accepts the weight.
- `w_data` output DATA_WIDTH: weight word.
- `w_last` output 1: the presented word is the final word of the burst.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- **IDLE, `start` high, `len` nonzero:** latch `base_addr` and `len`, then go to FETCH.
- **IDLE, `start` high, `len` = 0:** no reads are issued. `done` pulses in the next cycle and the FSM stays in IDLE.
- **FETCH read issue:** assert `mem_en` in any cycle where issued < len and (fifo_count + inflight) < FIFO_DEPTH. Both values in that check are registered; there is no same-cycle pop bypass.
- **Address sequence:** `mem_addr` = base + issued, modulo 2^ADDR_WIDTH. The address wraps from 1023 to 0 when `ADDR_WIDTH` = 10.
- **FETCH to DRAIN:** taken once the final read has been issued.
- **Capture:** `inflight` is a 1-bit register set by each `mem_en`. In the next cycle `mem_rdata` is pushed into the FIFO. Overflow cannot occur by construction.
- **Output stream:** `w_valid` = FIFO not empty, and `w_data` = FIFO head. A word transfers when `w_valid` and `w_ready` are both high.
- **Last marker:** a popped-word counter drives `w_last`, which is high exactly when the head is word len-1.
- **DRAIN to IDLE:** taken on the handshake of the last word. `done` pulses in the following cycle.
- **Start while busy:** ignored, with no effect on the latched values.
- **Downstream holding rules:** while `w_ready` is low, `w_data` and `w_last` hold stable, and `w_valid` never drops once it is asserted.

## Timing
- **Reset values:** `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0, `w_valid`=0, `w_last`=0, `w_data`=0. The FIFO pointers, counters and `inflight` are all cleared.
- **Reset mid-burst:** the burst is aborted immediately and no `done` is produced. Any pending memory read is discarded.
- **Start-to-data latency** (start sampled at edge 0):
  - `mem_en` is high in cycle 1.
  - Data arrives on `mem_rdata` in cycle 2 and is pushed at edge 3.
  - `w_valid` rises in cycle 3.
- **Throughput:** with `w_ready` held high and `FIFO_DEPTH` ≥ 3, one word per cycle. A burst of N words completes its last handshake in cycle N+2, and `done` is in cycle N+3.
- **Back-to-back bursts:** `start` is accepted in the `done` cycle, since the FSM is already in IDLE.
- **Simultaneous push and pop:** the occupancy count is unchanged. Pop from an empty FIFO cannot happen because the pop is gated by `w_valid`.
- **Backpressure:** when `w_ready` is low, issuing stops once fifo_count + inflight = FIFO_DEPTH. Issuing resumes in the cycle after the first pop.
- **Counter widths:** issued and popped counters are ADDR_WIDTH+1 bits, so `len` = 2^ADDR_WIDTH is legal.

## Test plan
- **Basic burst:** reset, then `start` with base=0x010, len=8 and memory preloaded with mem[i]=i, with `w_ready`=1. Required: `mem_en` in cycles 1–8, addresses 0x010–0x017; `w_data` 0x10..0x17 in cycles 3–10; `w_last` only in cycle 10; `done` in cycle 11.
- **Wrap-around:** base=0x3FE, len=4. Required: addresses 0x3FE, 0x3FF, 0x000, 0x001 in order, with data matching.
- **Backpressure:** len=16 with `w_ready` low for cycles 4–12. Required:
  - at most FIFO_DEPTH words are buffered and `mem_en` goes low;
  - `w_data` holds stable;
  - all 16 words are delivered in order with no loss or duplication.
- **Zero length and start while busy:** `start` with len=0 gives `done` next cycle and no `mem_en`. A second `start` mid-burst with base=0x200 is ignored and the original sequence completes.
- **Full memory and back-to-back:** len=1024 produces 1024 words with `w_last` on word 1023. A new `start` in the `done` cycle is accepted.
- **Async reset mid-burst:** assert `rst_n`=0 at word 5 of 10. Required: all outputs take reset values immediately and no `done` is produced; a subsequent burst behaves as in the basic burst test.
